// File: rtl/btb_pkg.sv
// Shared types and constants for the BTB update path.
package btb_pkg;

    localparam int BTB_INDEX_BITS = 10;
    localparam int BTB_TAG_BITS   = 22;

    // One resolved branch waiting to be written into the BTB.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic        taken;
    } btb_update_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        COMMIT = 2'd2,
        FLUSH  = 2'd3
    } sched_state_e;

    // Bundle the execute-stage resolution fields into one queue entry.
    function automatic btb_update_t make_update(input logic [31:0] pc,
                                                input logic [31:0] target,
                                                input logic        taken);
        btb_update_t u;
        u.pc     = pc;
        u.target = target;
        u.taken  = taken;
        return u;
    endfunction

endpackage

// File: rtl/btb_update_fifo.sv
// Small FIFO of pending BTB updates with synchronous clear.
module btb_update_fifo
    import btb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  btb_update_t                  push_data,
    input  logic                         pop,
    input  logic                         clear,
    output btb_update_t                  head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);

    btb_update_t        mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Pointer and occupancy bookkeeping; clear wins over any push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (!push && pop) count <= count - CW'(1);
        end
    end

    // Entry storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/btb_update_scheduler.sv
// Sequences resolved-branch updates into the BTB write port as
// SETUP/COMMIT pairs and owns the single-cycle BTB flush.
module btb_update_scheduler
    import btb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                        btb_upd_clk,
    input  logic                        btb_upd_reset,
    input  logic                        ex_valid,
    output logic                        ex_ready,
    input  logic [31:0]                 ex_pc,
    input  logic [31:0]                 ex_target,
    input  logic                        ex_taken,
    input  logic                        stall,
    input  logic                        flush_req,
    output logic                        flush_ack,
    output logic                        btb_write,
    output logic [31:0]                 btb_new_pc,
    output logic [31:0]                 btb_data,
    output logic                        btb_branch_taken,
    output logic                        btb_reset,
    output logic [$clog2(DEPTH+1)-1:0]  queue_count,
    output logic [CNT_W-1:0]            upd_count
);

    sched_state_e state;
    sched_state_e state_next;

    btb_update_t  in_upd;
    btb_update_t  fifo_head;
    btb_update_t  head_sel;
    logic         fifo_full;
    logic         fifo_empty;
    logic         fifo_push;
    logic         fifo_pop;
    logic         push;
    logic         avail;
    logic         start;

    // Fullness is judged before any same-cycle pop, so a full queue refuses.
    assign ex_ready = !fifo_full && (state != FLUSH);
    assign push     = ex_valid && ex_ready;
    assign in_upd   = make_update(ex_pc, ex_target, ex_taken);

    // An offer arriving at an empty queue can start immediately; it bypasses
    // the storage so SETUP follows the push by a single edge.
    assign avail     = !fifo_empty || push;
    assign head_sel  = fifo_empty ? in_upd : fifo_head;
    assign fifo_pop  = start && !fifo_empty;
    assign fifo_push = push && !(start && fifo_empty);

    btb_update_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (btb_upd_clk),
        .rst       (btb_upd_reset),
        .push      (fifo_push),
        .push_data (in_upd),
        .pop       (fifo_pop),
        .clear     (state == FLUSH),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (queue_count)
    );

    // Next-state decode; start marks the cycle an update leaves the queue.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        case (state)
            IDLE: begin
                if (flush_req) begin
                    state_next = FLUSH;
                end else if (avail && !stall) begin
                    start      = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                state_next = COMMIT;
            end
            COMMIT: begin
                if (flush_req) begin
                    state_next = FLUSH;
                end else if (avail && !stall) begin
                    start      = 1'b1;
                    state_next = SETUP;
                end else begin
                    state_next = IDLE;
                end
            end
            FLUSH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Scheduler state register.
    always_ff @(posedge btb_upd_clk or posedge btb_upd_reset) begin
        if (btb_upd_reset) state <= IDLE;
        else               state <= state_next;
    end

    // Registered BTB strobes and the held update payload for the pair.
    always_ff @(posedge btb_upd_clk or posedge btb_upd_reset) begin
        if (btb_upd_reset) begin
            btb_write        <= 1'b0;
            btb_reset        <= 1'b0;
            flush_ack        <= 1'b0;
            btb_new_pc       <= '0;
            btb_data         <= '0;
            btb_branch_taken <= 1'b0;
        end else begin
            btb_write <= (state_next == COMMIT);
            btb_reset <= (state_next == FLUSH);
            flush_ack <= (state_next == FLUSH);
            if (start) begin
                btb_new_pc       <= head_sel.pc;
                btb_data         <= head_sel.target;
                btb_branch_taken <= head_sel.taken;
            end
        end
    end

    // Committed-update counter; survives flush and wraps naturally.
    always_ff @(posedge btb_upd_clk or posedge btb_upd_reset) begin
        if (btb_upd_reset)        upd_count <= '0;
        else if (state == COMMIT) upd_count <= upd_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_btb_update_scheduler.sv
// Bench for btb_update_scheduler: queue-based reference model, per-cycle
// compare, directed scenarios and a randomized run.
module tb_btb_update_scheduler;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;
    localparam int QW    = $clog2(DEPTH + 1);

    logic              btb_upd_clk = 1'b0;
    logic              btb_upd_reset;
    logic              ex_valid;
    logic              ex_ready;
    logic [31:0]       ex_pc;
    logic [31:0]       ex_target;
    logic              ex_taken;
    logic              stall;
    logic              flush_req;
    logic              flush_ack;
    logic              btb_write;
    logic [31:0]       btb_new_pc;
    logic [31:0]       btb_data;
    logic              btb_branch_taken;
    logic              btb_reset;
    logic [QW-1:0]     queue_count;
    logic [CNT_W-1:0]  upd_count;

    always #5 btb_upd_clk = ~btb_upd_clk;

    btb_update_scheduler #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .btb_upd_clk      (btb_upd_clk),
        .btb_upd_reset    (btb_upd_reset),
        .ex_valid         (ex_valid),
        .ex_ready         (ex_ready),
        .ex_pc            (ex_pc),
        .ex_target        (ex_target),
        .ex_taken         (ex_taken),
        .stall            (stall),
        .flush_req        (flush_req),
        .flush_ack        (flush_ack),
        .btb_write        (btb_write),
        .btb_new_pc       (btb_new_pc),
        .btb_data         (btb_data),
        .btb_branch_taken (btb_branch_taken),
        .btb_reset        (btb_reset),
        .queue_count      (queue_count),
        .upd_count        (upd_count)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Pending updates live in a queue; pair_left counts the cycles of the
    // current SETUP/COMMIT pair still to be shown (2 = first, 1 = write cycle).
    typedef struct {
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        tk;
    } ent_t;

    ent_t             q[$];
    int               pair_left;
    bit               m_flush;
    logic             m_write;
    logic             m_reset;
    logic [31:0]      m_pc;
    logic [31:0]      m_data;
    logic             m_taken;
    logic [CNT_W-1:0] m_upd;
    int               n_push = 0;

    always @(posedge btb_upd_clk or posedge btb_upd_reset) begin
        if (btb_upd_reset) begin
            q.delete();
            pair_left = 0;
            m_flush   = 0;
            m_write   = 0;
            m_reset   = 0;
            m_pc      = 0;
            m_data    = 0;
            m_taken   = 0;
            m_upd     = 0;
        end else begin
            int  nl;
            bit  nf;
            bit  acc;
            ent_t e;
            acc = ex_valid && (q.size() < DEPTH) && !m_flush;
            if (acc) begin
                e.pc = ex_pc; e.tgt = ex_target; e.tk = ex_taken;
                q.push_back(e);
                n_push++;
            end
            nl = 0;
            nf = 0;
            if (m_flush) begin
                q.delete();
            end else if (pair_left == 2) begin
                nl = 1;
            end else begin
                if (pair_left == 1) m_upd = m_upd + 16'd1;
                if (flush_req) begin
                    nf = 1;
                end else if (q.size() > 0 && !stall) begin
                    e = q.pop_front();
                    m_pc = e.pc; m_data = e.tgt; m_taken = e.tk;
                    nl = 2;
                end
            end
            pair_left = nl;
            m_flush   = nf;
            m_write   = (nl == 1);
            m_reset   = nf;
        end
    end

    // Every cycle out of reset, every output against the model.
    always @(negedge btb_upd_clk) begin
        if (!btb_upd_reset) begin
            cmp("ex_ready",         32'(ex_ready),         32'((q.size() < DEPTH) && !m_flush));
            cmp("btb_write",        32'(btb_write),        32'(m_write));
            cmp("btb_reset",        32'(btb_reset),        32'(m_reset));
            cmp("flush_ack",        32'(flush_ack),        32'(m_reset));
            cmp("btb_new_pc",       btb_new_pc,            m_pc);
            cmp("btb_data",         btb_data,              m_data);
            cmp("btb_branch_taken", 32'(btb_branch_taken), 32'(m_taken));
            cmp("queue_count",      32'(queue_count),      32'(q.size()));
            cmp("upd_count",        32'(upd_count),        32'(m_upd));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [8:0]  wmask;
        logic [31:0] pcs[$];
        int          base;

        btb_upd_reset = 1'b1;
        ex_valid = 0; ex_pc = 0; ex_target = 0; ex_taken = 0;
        stall = 0; flush_req = 0;
        repeat (3) @(negedge btb_upd_clk);
        btb_upd_reset = 1'b0;

        cmp("rst_upd_count",   32'(upd_count),   32'd0);
        cmp("rst_queue_count", 32'(queue_count), 32'd0);
        cmp("rst_ex_ready",    32'(ex_ready),    32'd1);
        cmp("rst_btb_write",   32'(btb_write),   32'd0);

        // Single update: SETUP next cycle, write two cycles after push.
        ex_valid = 1; ex_pc = 32'h40; ex_target = 32'h100; ex_taken = 1;
        @(negedge btb_upd_clk);
        ex_valid = 0;
        cmp("t1_setup_write", 32'(btb_write), 32'd0);
        cmp("t1_setup_pc",    btb_new_pc,     32'h40);
        @(negedge btb_upd_clk);
        cmp("t1_commit_write", 32'(btb_write),        32'd1);
        cmp("t1_commit_pc",    btb_new_pc,            32'h40);
        cmp("t1_commit_data",  btb_data,              32'h100);
        cmp("t1_commit_taken", 32'(btb_branch_taken), 32'd1);
        @(negedge btb_upd_clk);
        cmp("t1_after_write", 32'(btb_write), 32'd0);
        cmp("t1_upd_count",   32'(upd_count), 32'd1);
        repeat (2) @(negedge btb_upd_clk);

        // Back-to-back: writes in cycles 2, 4, 6 in push order.
        for (int c = 0; c < 9; c++) begin
            if (c > 0) @(negedge btb_upd_clk);
            wmask[c] = btb_write;
            if (btb_write) pcs.push_back(btb_new_pc);
            ex_valid  = (c < 3);
            ex_pc     = 32'h200 + 32'(c * 16);
            ex_target = 32'h900 + 32'(c);
            ex_taken  = c[0];
        end
        ex_valid = 0;
        cmp("b2b_wmask",  32'(wmask),      32'h054);
        cmp("b2b_nwrite", 32'(pcs.size()), 32'd3);
        if (pcs.size() == 3) begin
            cmp("b2b_pc0", pcs[0], 32'h200);
            cmp("b2b_pc1", pcs[1], 32'h210);
            cmp("b2b_pc2", pcs[2], 32'h220);
        end
        repeat (3) @(negedge btb_upd_clk);

        // Fill under stall: four accepted, fifth held until the first pop.
        stall = 1;
        base = n_push;
        ex_valid = 1; ex_pc = 32'h1000; ex_target = 32'h5000; ex_taken = 0;
        for (int i = 0; i < 20 && (n_push - base) < 4; i++) begin
            @(negedge btb_upd_clk);
            ex_pc     = 32'h1000 + 32'(4 * (n_push - base));
            ex_target = 32'h5000 + 32'(n_push - base);
        end
        cmp("fill_accepts",   32'(n_push - base), 32'd4);
        cmp("fill_qc_full",   32'(queue_count),   32'd4);
        cmp("fill_ready_low", 32'(ex_ready),      32'd0);
        repeat (3) @(negedge btb_upd_clk);
        cmp("fill_held_ready", 32'(ex_ready),       32'd0);
        cmp("fill_held_count", 32'(n_push - base),  32'd4);
        stall = 0;
        @(negedge btb_upd_clk);
        cmp("fill_ready_after_pop", 32'(ex_ready),    32'd1);
        cmp("fill_qc_after_pop",    32'(queue_count), 32'd3);
        @(negedge btb_upd_clk);
        cmp("fill_fifth_accepted", 32'(n_push - base), 32'd5);
        ex_valid = 0;
        repeat (12) @(negedge btb_upd_clk);

        // Flush raised during SETUP: COMMIT completes, then one flush cycle.
        ex_valid = 1; ex_pc = 32'hA0; ex_target = 32'hB0; ex_taken = 1;
        @(negedge btb_upd_clk);
        ex_pc = 32'hA4; flush_req = 1;
        @(negedge btb_upd_clk);
        ex_pc = 32'hA8;
        cmp("fq_commit_write", 32'(btb_write), 32'd1);
        cmp("fq_commit_pc",    btb_new_pc,     32'hA0);
        @(negedge btb_upd_clk);
        ex_valid = 0;
        cmp("fq_flush_ack",   32'(flush_ack), 32'd1);
        cmp("fq_btb_reset",   32'(btb_reset), 32'd1);
        cmp("fq_flush_write", 32'(btb_write), 32'd0);
        cmp("fq_flush_ready", 32'(ex_ready),  32'd0);
        flush_req = 0;
        @(negedge btb_upd_clk);
        cmp("fq_qc_cleared", 32'(queue_count), 32'd0);
        cmp("fq_ack_pulse",  32'(flush_ack),   32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge btb_upd_clk);
            cmp("fq_no_write", 32'(btb_write), 32'd0);
        end

        // Flush has priority over a queued entry in IDLE.
        stall = 1;
        ex_valid = 1; ex_pc = 32'hC0; ex_target = 32'hC4; ex_taken = 0;
        @(negedge btb_upd_clk);
        ex_valid = 0;
        cmp("fp_qc_one", 32'(queue_count), 32'd1);
        stall = 0; flush_req = 1;
        @(negedge btb_upd_clk);
        cmp("fp_ack",        32'(flush_ack), 32'd1);
        cmp("fp_ready_low",  32'(ex_ready),  32'd0);
        cmp("fp_no_write",   32'(btb_write), 32'd0);
        flush_req = 0;
        @(negedge btb_upd_clk);
        cmp("fp_qc_zero", 32'(queue_count), 32'd0);
        @(negedge btb_upd_clk);
        cmp("fp_discarded", 32'(btb_write), 32'd0);
        repeat (2) @(negedge btb_upd_clk);

        // Randomized traffic; requester drops flush_req on flush_ack.
        for (int i = 0; i < 800; i++) begin
            @(negedge btb_upd_clk);
            ex_valid  = ($urandom_range(0, 2) != 0);
            ex_pc     = $urandom;
            ex_target = $urandom;
            ex_taken  = $urandom_range(0, 1) == 1;
            stall     = ($urandom_range(0, 3) == 0);
            if (flush_ack)                                   flush_req = 0;
            else if (!flush_req && $urandom_range(0, 39) == 0) flush_req = 1;
        end
        @(negedge btb_upd_clk);
        ex_valid = 0; stall = 0; flush_req = 0;
        repeat (12) @(negedge btb_upd_clk);

        // Asynchronous reset in the middle of a COMMIT cycle.
        ex_valid = 1; ex_pc = 32'hE0; ex_target = 32'hE4; ex_taken = 1;
        @(negedge btb_upd_clk);
        ex_valid = 1; ex_pc = 32'hE8;
        @(negedge btb_upd_clk);
        ex_valid = 0;
        cmp("ar_pre_write",   32'(btb_write),        32'd1);
        cmp("ar_pre_upd_nz",  32'(upd_count != 0),   32'd1);
        #1 btb_upd_reset = 1'b1;
        #1;
        cmp("ar_write",     32'(btb_write),        32'd0);
        cmp("ar_upd_count", 32'(upd_count),        32'd0);
        cmp("ar_pc",        btb_new_pc,            32'd0);
        cmp("ar_data",      btb_data,              32'd0);
        cmp("ar_taken",     32'(btb_branch_taken), 32'd0);
        cmp("ar_qc",        32'(queue_count),      32'd0);
        cmp("ar_btb_reset", 32'(btb_reset),        32'd0);
        cmp("ar_flush_ack", 32'(flush_ack),        32'd0);
        @(negedge btb_upd_clk);
        btb_upd_reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge btb_upd_clk);
            cmp("ar_no_resume", 32'(btb_write), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/btb_update_scheduler.md
Name: btb_update_scheduler

Overview:
Sequences branch-resolution updates from decode/execute into the branch_target_buffer write port. Buffers resolved branches in a small FIFO and presents each one across a two-cycle SETUP/COMMIT pair. The pair is required because the BTB registers its write index one cycle before the write is applied. Also owns the BTB flush: it drains the queue and pulses the BTB reset for one cycle.

Parameters:
DEPTH, 4, update FIFO entries; power of two, >= 2
CNT_W, 16, width of committed-update counter

Ports:
btb_upd_clk  in  1  clock
btb_upd_reset  in  1  asynchronous, active-high reset
ex_valid  in  1  resolved branch offered
ex_ready  out  1  scheduler accepts offer this cycle
ex_pc  in  32  PC of resolved branch
ex_target  in  32  resolved branch target
ex_taken  in  1  branch outcome
stall  in  1  inhibits starting a new update
flush_req  in  1  level request to invalidate the BTB
flush_ack  out  1  one-cycle pulse when flush is performed
btb_write  out  1  to BTB btb_write
btb_new_pc  out  32  to BTB btb_new_pc
btb_data  out  32  to BTB btb_data
btb_branch_taken  out  1  to BTB btb_branch_taken
btb_reset  out  1  to BTB btb_reset (synchronous in BTB)
queue_count  out  $clog2(DEPTH+1)  FIFO occupancy
upd_count  out  CNT_W  committed updates, wraps

Behaviour:
- All outputs registered except ex_ready, which is combinational from registered state.
- Reset values: state IDLE; FIFO empty; queue_count 0; upd_count 0; btb_write 0; btb_reset 0; flush_ack 0; btb_new_pc 0; btb_data 0; btb_branch_taken 0.
- Reset is asynchronous and may assert mid-operation, including during COMMIT. All of the above return to reset values immediately, with no partial write sequencing afterwards.
- ex_ready = !full && state != FLUSH.
- Push occurs when ex_valid && ex_ready. Fullness is evaluated before any same-cycle pop, so push is refused at full even if a pop happens that cycle.
- FIFO order is strict FIFO; there is no coalescing of duplicate PCs.
- IDLE:
  - flush_req -> FLUSH (takes priority over a pending update).
  - else if !empty && !stall -> pop head into btb_new_pc/btb_data/btb_branch_taken, go to SETUP.
- SETUP: outputs hold the popped values; btb_write = 0; go to COMMIT unconditionally. flush_req and stall are ignored here.
- COMMIT:
  - Outputs hold the same values; btb_write = 1 for exactly this cycle; upd_count += 1 (mod 2^CNT_W).
  - Next state: flush_req -> FLUSH; else if !empty && !stall -> pop next head, go to SETUP; else IDLE.
- Throughput: one update per 2 cycles. btb_new_pc/btb_data/btb_branch_taken never change between SETUP and the end of COMMIT.
- Latency: a push into an empty FIFO in IDLE with no stall reaches SETUP on the next edge. btb_write is asserted 2 cycles after the push cycle.
- FLUSH (one cycle):
  - btb_reset = 1 and flush_ack = 1 during this cycle.
  - FIFO cleared: queued updates are discarded and queue_count becomes 0 next cycle.
  - ex_ready = 0; go to IDLE.
  - If flush_req is still high in IDLE, another flush occurs; the requester drops flush_req on flush_ack.
- stall only gates SETUP entry. A SETUP/COMMIT pair already begun always completes.
- btb_reset and btb_write are never high in the same cycle.
- queue_count reflects pushes/pops from the previous edge. upd_count is not cleared by flush.

Decomposition:
- Package btb_pkg:
  - btb_update_t struct {pc[31:0], target[31:0], taken}
  - sched_state_e enum {IDLE, SETUP, COMMIT, FLUSH}
  - BTB_INDEX_BITS = 10
  - BTB_TAG_BITS = 22
- One sub-module: btb_update_fifo, a parameterised DEPTH FIFO of btb_update_t with push/pop/full/empty/count/clear. The scheduler FSM stays in the top module.

Test Plan:
- Single update: push pc=0x0000_0040, target=0x0000_0100, taken=1 at cycle 0.
  -> SETUP at cycle 1, btb_write=1 only at cycle 2 with btb_new_pc=0x40, btb_data=0x100, btb_branch_taken=1; upd_count=1.
- Back-to-back: push 3 updates on consecutive cycles.
  -> btb_write high at cycles 2, 4, 6 with PCs in push order; outputs stable across each SETUP/COMMIT pair.
- Fill with stall=1: push 5 offers, DEPTH=4.
  -> ex_ready=0 after the 4th accept; queue_count=4; 5th held. Release stall -> 5th accepted the cycle after the first pop.
- Flush with queue: 3 entries queued, flush_req raised during SETUP.
  -> current COMMIT completes; next cycle btb_reset=1, flush_ack=1; queue_count=0 afterwards; no further btb_write.
- Flush priority in IDLE: flush_req and a queued entry simultaneously.
  -> FLUSH taken first; entry discarded; ex_ready=0 in the flush cycle.
- Async reset mid-COMMIT: assert btb_upd_reset between edges.
  -> btb_write drops immediately; all outputs at reset values; upd_count=0.
